icache_param: RTL and testbench

- Parametrised direct-mapped, read-only instruction cache between the CPU fetch port and a block-wide instruction memory.
- Replaces the ideal fetch array with a cached path that stalls the CPU through BUSYWAIT on misses.
- Generalises line count, block size, word width and address width.
- Adds three features the fixed-size data cache lacks: flush, saturating hit/miss counters, and double-count suppression after a refill.

---
 rtl/icache_param_if.sv | 33 +++
 rtl/icache_param.sv | 146 ++++++++++++++
 tb/tb_icache_param.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_param_if.sv
// Fetch-side and memory-side signal bundle for the parametrised instruction cache.
interface icache_param_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WORD_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
);
    localparam int OFF = $clog2(WORDS_PER_BLOCK) + $clog2(WORD_WIDTH / 8);

    logic                                  READ;
    logic [ADDR_WIDTH-1:0]                 ADDRESS;
    logic                                  FLUSH;
    logic [WORD_WIDTH-1:0]                 INSTRUCTION;
    logic                                  BUSYWAIT;
    logic                                  mem_read;
    logic [ADDR_WIDTH-OFF-1:0]             mem_address;
    logic [WORD_WIDTH*WORDS_PER_BLOCK-1:0] mem_readdata;
    logic                                  mem_busywait;
    logic [CNT_WIDTH-1:0]                  HIT_COUNT;
    logic [CNT_WIDTH-1:0]                  MISS_COUNT;

    // CPU plus instruction memory side
    modport master (
        output READ, ADDRESS, FLUSH, mem_readdata, mem_busywait,
        input  INSTRUCTION, BUSYWAIT, mem_read, mem_address, HIT_COUNT, MISS_COUNT
    );

    // Cache side
    modport slave (
        input  READ, ADDRESS, FLUSH, mem_readdata, mem_busywait,
        output INSTRUCTION, BUSYWAIT, mem_read, mem_address, HIT_COUNT, MISS_COUNT
    );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped read-only instruction cache with flush and saturating hit/miss counters.
module icache_param #(
    parameter int ADDR_WIDTH      = 10,
    parameter int LINES           = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int WORD_WIDTH      = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    icache_param_if.slave bus
);
    localparam int BYTE    = $clog2(WORD_WIDTH / 8);
    localparam int WSEL    = $clog2(WORDS_PER_BLOCK);
    localparam int OFF     = WSEL + BYTE;
    localparam int IDX     = $clog2(LINES);
    localparam int TAG     = ADDR_WIDTH - IDX - OFF;
    localparam int BLK_W   = ADDR_WIDTH - OFF;
    localparam int BLOCK_W = WORD_WIDTH * WORDS_PER_BLOCK;

    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

    state_t state_reg, state_next;

    logic [LINES-1:0]     valid_reg, valid_next;
    logic [TAG-1:0]       tag_mem  [LINES];
    logic [BLOCK_W-1:0]   data_mem [LINES];
    logic [BLK_W-1:0]     blk_reg;          // block address latched at the miss
    logic                 first_reg;        // first MEM_READ cycle, memory busywait not yet trusted
    logic                 after_update_reg; // IDLE cycle right after a refill
    logic [CNT_WIDTH-1:0] hit_count_reg, miss_count_reg;

    logic [IDX-1:0] idx, fill_idx;
    logic [TAG-1:0] tag, fill_tag;
    logic           hit, miss_start, refill_done, count_hit;

    assign idx      = bus.ADDRESS[OFF +: IDX];
    assign tag      = bus.ADDRESS[ADDR_WIDTH-1 -: TAG];
    assign fill_idx = blk_reg[IDX-1:0];
    assign fill_tag = blk_reg[BLK_W-1 -: TAG];

    assign hit         = bus.READ && valid_reg[idx] && (tag_mem[idx] == tag);
    assign miss_start  = (state_reg == IDLE) && bus.READ && !hit;
    assign refill_done = (state_reg == MEM_READ) && !first_reg && !bus.mem_busywait;
    assign count_hit   = (state_reg == IDLE) && hit && !after_update_reg;

    // Word select out of the indexed line
    logic [BLOCK_W-1:0]    line_data;
    logic [WORD_WIDTH-1:0] line_words [WORDS_PER_BLOCK];
    assign line_data = data_mem[idx];

    generate
        for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_word
            assign line_words[gi] = line_data[gi*WORD_WIDTH +: WORD_WIDTH];
        end
        if (WSEL > 0) begin : g_sel
            logic [WSEL-1:0] word_sel;
            assign word_sel        = bus.ADDRESS[BYTE +: WSEL];
            assign bus.INSTRUCTION = line_words[word_sel];
        end else begin : g_nosel
            assign bus.INSTRUCTION = line_words[0];
        end
    endgenerate

    assign bus.mem_address = blk_reg;
    assign bus.HIT_COUNT   = hit_count_reg;
    assign bus.MISS_COUNT  = miss_count_reg;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (miss_start)  state_next = MEM_READ;
            MEM_READ: if (refill_done) state_next = UPDATE;
            UPDATE:                    state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.BUSYWAIT = 1'b0;
        bus.mem_read = 1'b0;
        case (state_reg)
            IDLE:     bus.BUSYWAIT = bus.READ && !hit;
            MEM_READ: begin
                bus.BUSYWAIT = 1'b1;
                bus.mem_read = 1'b1;
            end
            UPDATE:   bus.BUSYWAIT = 1'b1;
            default:  ;
        endcase
    end

    // Refill bookkeeping flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            first_reg        <= 1'b0;
            after_update_reg <= 1'b0;
        end else begin
            first_reg        <= miss_start;
            after_update_reg <= (state_reg == UPDATE);
        end
    end

    // Block address is captured once per miss and held for the whole refill
    always_ff @(posedge CLK) begin
        if (miss_start) blk_reg <= bus.ADDRESS[ADDR_WIDTH-1:OFF];
    end

    // Valid bits: flush clears first, a completing refill then sets its line
    always_comb begin
        valid_next = bus.FLUSH ? '0 : valid_reg;
        if (refill_done) valid_next[fill_idx] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) valid_reg <= '0;
        else       valid_reg <= valid_next;
    end

    // Tag and data storage; reset leaves contents alone but drops an in-flight refill
    always_ff @(posedge CLK) begin
        if (!RESET && refill_done) begin
            data_mem[fill_idx] <= bus.mem_readdata;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (count_hit && hit_count_reg != '1)   hit_count_reg  <= hit_count_reg + 1'b1;
            if (miss_start && miss_count_reg != '1) miss_count_reg <= miss_count_reg + 1'b1;
        end
    end
endmodule

// File: tb/tb_icache_param.sv
// Self-checking bench for icache_param: directed scenarios plus a randomized run
// against a line-level reference model; a second small instance covers saturation.
module tb_icache_param;
    localparam int AW   = 10;
    localparam int LN   = 8;
    localparam int WPB  = 4;
    localparam int WW   = 32;
    localparam int CW   = 16;
    localparam int OFF  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_param_if #(.ADDR_WIDTH(AW), .WORDS_PER_BLOCK(WPB), .WORD_WIDTH(WW), .CNT_WIDTH(CW)) bus ();
    icache_param #(.ADDR_WIDTH(AW), .LINES(LN), .WORDS_PER_BLOCK(WPB), .WORD_WIDTH(WW), .CNT_WIDTH(CW))
        dut (.CLK(clk), .RESET(rst), .bus(bus));

    icache_param_if #(.ADDR_WIDTH(10), .WORDS_PER_BLOCK(2), .WORD_WIDTH(32), .CNT_WIDTH(2)) bus2 ();
    icache_param #(.ADDR_WIDTH(10), .LINES(4), .WORDS_PER_BLOCK(2), .WORD_WIDTH(32), .CNT_WIDTH(2))
        dut2 (.CLK(clk), .RESET(rst), .bus(bus2));

    int compared   = 0;
    int mismatched = 0;

    // Instruction memory contents: every (block, word) pair gets a unique value
    function automatic logic [31:0] mem_word(input int blk, input int w);
        return 32'hA500_0000 | (32'(blk) << 8) | 32'(w);
    endfunction

    always_comb begin
        bus.mem_readdata = '0;
        for (int w = 0; w < WPB; w++)
            bus.mem_readdata[w*WW +: WW] = mem_word(int'(bus.mem_address), w);
    end

    always_comb begin
        bus2.mem_readdata = '0;
        for (int w = 0; w < 2; w++)
            bus2.mem_readdata[w*32 +: 32] = mem_word(int'(bus2.mem_address), w);
    end
    assign bus2.mem_busywait = 1'b0;

    // Memory busy for 'lat' cycles of each read request, then ready
    int   lat       = 2;
    int   rd_cycles = 0;
    logic mem_busy  = 1'b0;
    assign bus.mem_busywait = mem_busy;
    always @(negedge clk) begin
        if (bus.mem_read === 1'b1) begin
            mem_busy  <= (rd_cycles < lat);
            rd_cycles <= rd_cycles + 1;
        end else begin
            mem_busy  <= 1'b0;
            rd_cycles <= 0;
        end
    end

    // Reference model: which block each line holds, plus counters
    bit mv [LN];
    int mt [LN];
    int mh = 0;
    int mm = 0;

    function automatic void model_clear();
        for (int i = 0; i < LN; i++) mv[i] = 1'b0;
    endfunction

    function automatic bit model_access(input int addr);
        int blk = addr >> OFF;
        int li  = blk % LN;
        int tg  = blk / LN;
        bit h   = mv[li] && (mt[li] == tg);
        if (h) begin
            if (mh < CMAX) mh++;
        end else begin
            if (mm < CMAX) mm++;
            mv[li] = 1'b1;
            mt[li] = tg;
        end
        return h;
    endfunction

    function automatic logic [31:0] exp_word(input int addr);
        return mem_word(addr >> OFF, (addr >> 2) % WPB);
    endfunction

    // Present one fetch and wait until it is accepted; READ stays high on return
    task automatic fetch(input int addr, output int stall, output logic [31:0] instr, output int maddr);
        bit seen = 1'b0;
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 10'(addr);
        bus.FLUSH   = 1'b0;
        stall = 0;
        maddr = -1;
        #1;
        while (bus.BUSYWAIT !== 1'b0 && stall < 60) begin
            if (bus.mem_read === 1'b1 && !seen) begin
                seen  = 1'b1;
                maddr = int'(bus.mem_address);
            end
            stall++;
            @(negedge clk);
            #1;
        end
        instr = bus.INSTRUCTION;
        $display("fetch addr=%03h stall=%0d mem_addr=%0d instr=%08h", addr, stall, maddr, instr);
    endtask

    task automatic fetch2(input int addr, output int stall, output logic [31:0] instr, output int maddr);
        bit seen = 1'b0;
        @(negedge clk);
        bus2.READ    = 1'b1;
        bus2.ADDRESS = 10'(addr);
        bus2.FLUSH   = 1'b0;
        stall = 0;
        maddr = -1;
        #1;
        while (bus2.BUSYWAIT !== 1'b0 && stall < 60) begin
            if (bus2.mem_read === 1'b1 && !seen) begin
                seen  = 1'b1;
                maddr = int'(bus2.mem_address);
            end
            stall++;
            @(negedge clk);
            #1;
        end
        instr = bus2.INSTRUCTION;
        $display("fetch2 addr=%03h stall=%0d mem_addr=%0d instr=%08h", addr, stall, maddr, instr);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.READ  = 1'b0;
            bus2.READ = 1'b0;
            bus.FLUSH = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        compared += 4;
        if (bus.HIT_COUNT !== 16'd0)  begin mismatched++; $display("FAIL reset_hit got=%0d want=0", bus.HIT_COUNT); end
        if (bus.MISS_COUNT !== 16'd0) begin mismatched++; $display("FAIL reset_miss got=%0d want=0", bus.MISS_COUNT); end
        if (bus.BUSYWAIT !== 1'b0)    begin mismatched++; $display("FAIL reset_busywait got=%b want=0", bus.BUSYWAIT); end
        if (bus.mem_read !== 1'b0)    begin mismatched++; $display("FAIL reset_mem_read got=%b want=0", bus.mem_read); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        mh = 0;
        mm = 0;
        $display("reset done");
    endtask

    task automatic test_cold_miss();
        int stall, maddr;
        logic [31:0] instr;
        lat = 5;
        void'(model_access(0));
        fetch(0, stall, instr, maddr);
        compared += 3;
        if (stall !== lat + 3)           begin mismatched++; $display("FAIL cold_stall got=%0d want=%0d", stall, lat + 3); end
        if (maddr !== 0)                 begin mismatched++; $display("FAIL cold_mem_addr got=%0d want=0", maddr); end
        if (instr !== mem_word(0, 0))    begin mismatched++; $display("FAIL cold_instr got=%08h want=%08h", instr, mem_word(0, 0)); end
        idle(1);
        compared += 2;
        if (bus.MISS_COUNT !== 16'd1) begin mismatched++; $display("FAIL cold_miss_count got=%0d want=1", bus.MISS_COUNT); end
        if (bus.HIT_COUNT !== 16'd0)  begin mismatched++; $display("FAIL cold_hit_count got=%0d want=0", bus.HIT_COUNT); end
    endtask

    task automatic test_spatial_hits();
        int stall, maddr;
        logic [31:0] instr;
        for (int i = 1; i < 4; i++) begin
            void'(model_access(4 * i));
            fetch(4 * i, stall, instr, maddr);
            compared += 2;
            if (stall !== 0)              begin mismatched++; $display("FAIL spatial_stall got=%0d want=0", stall); end
            if (instr !== mem_word(0, i)) begin mismatched++; $display("FAIL spatial_instr got=%08h want=%08h", instr, mem_word(0, i)); end
        end
        idle(1);
        compared++;
        if (bus.HIT_COUNT !== 16'd3) begin mismatched++; $display("FAIL spatial_hit_count got=%0d want=3", bus.HIT_COUNT); end
    endtask

    task automatic test_conflict();
        int stall, maddr;
        logic [31:0] instr;
        int addrs [2] = '{32'h080, 32'h000};
        lat = 2;
        foreach (addrs[i]) begin
            void'(model_access(addrs[i]));
            fetch(addrs[i], stall, instr, maddr);
            compared += 3;
            if (stall !== lat + 3)            begin mismatched++; $display("FAIL conflict_stall got=%0d want=%0d", stall, lat + 3); end
            if (maddr !== (addrs[i] >> OFF))  begin mismatched++; $display("FAIL conflict_mem_addr got=%0d want=%0d", maddr, addrs[i] >> OFF); end
            if (instr !== exp_word(addrs[i])) begin mismatched++; $display("FAIL conflict_instr got=%08h want=%08h", instr, exp_word(addrs[i])); end
        end
        idle(1);
        compared++;
        if (int'(bus.MISS_COUNT) !== mm) begin mismatched++; $display("FAIL conflict_miss_count got=%0d want=%0d", bus.MISS_COUNT, mm); end
    endtask

    task automatic test_flush();
        int stall, maddr;
        logic [31:0] instr;
        bit h;
        // hit concurrent with the flush edge still counts
        h = model_access(32'h004);
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 10'h004;
        bus.FLUSH   = 1'b1;
        #1;
        compared += 2;
        if (bus.BUSYWAIT !== !h)                 begin mismatched++; $display("FAIL flush_hit_busywait got=%b want=%b", bus.BUSYWAIT, !h); end
        if (bus.INSTRUCTION !== exp_word(32'h004)) begin mismatched++; $display("FAIL flush_hit_instr got=%08h want=%08h", bus.INSTRUCTION, exp_word(32'h004)); end
        model_clear();
        idle(1);
        compared++;
        if (int'(bus.HIT_COUNT) !== mh) begin mismatched++; $display("FAIL flush_hit_count got=%0d want=%0d", bus.HIT_COUNT, mh); end
        void'(model_access(32'h004));
        fetch(32'h004, stall, instr, maddr);
        compared += 2;
        if (stall !== lat + 3)            begin mismatched++; $display("FAIL flush_refetch_stall got=%0d want=%0d", stall, lat + 3); end
        if (instr !== exp_word(32'h004))  begin mismatched++; $display("FAIL flush_refetch_instr got=%08h want=%08h", instr, exp_word(32'h004)); end
    endtask

    task automatic test_flush_refill();
        int stall, maddr, n;
        logic [31:0] instr;
        bit seen = 1'b0;
        bit done = 1'b0;
        void'(model_access(32'h010));
        fetch(32'h010, stall, instr, maddr);
        // miss on 0x100 with FLUSH on the edge that completes the refill
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 10'h100;
        n = 0;
        while (!done && n < 40) begin
            #1;
            if (bus.mem_read === 1'b1 && seen && bus.mem_busywait === 1'b0) begin
                bus.FLUSH = 1'b1;
                done = 1'b1;
            end else begin
                if (bus.mem_read === 1'b1) seen = 1'b1;
                n++;
                @(negedge clk);
            end
        end
        compared++;
        if (!done) begin mismatched++; $display("FAIL flush_refill_wait got=timeout want=refill"); end
        model_clear();
        void'(model_access(32'h100));
        @(negedge clk);
        bus.FLUSH = 1'b0;
        #1;
        compared++;
        if (bus.BUSYWAIT !== 1'b1) begin mismatched++; $display("FAIL flush_refill_update got=%b want=1", bus.BUSYWAIT); end
        @(negedge clk);
        #1;
        compared += 2;
        if (bus.BUSYWAIT !== 1'b0)                 begin mismatched++; $display("FAIL flush_refill_valid got=%b want=0", bus.BUSYWAIT); end
        if (bus.INSTRUCTION !== exp_word(32'h100)) begin mismatched++; $display("FAIL flush_refill_instr got=%08h want=%08h", bus.INSTRUCTION, exp_word(32'h100)); end
        $display("flush+refill addr=100 busywait=%b instr=%08h", bus.BUSYWAIT, bus.INSTRUCTION);
        void'(model_access(32'h010));
        fetch(32'h010, stall, instr, maddr);
        compared++;
        if (stall !== lat + 3) begin mismatched++; $display("FAIL flush_refill_other got=%0d want=%0d", stall, lat + 3); end
    endtask

    task automatic test_reset_mid_refill();
        int stall, maddr, n, rd;
        logic [31:0] instr;
        lat = 5;
        @(negedge clk);
        bus.READ    = 1'b1;
        bus.ADDRESS = 10'h3C0;
        n  = 0;
        rd = 0;
        while (rd < 3 && n < 40) begin
            #1;
            if (bus.mem_read === 1'b1) rd++;
            if (rd == 3) begin
                rst      = 1'b1;
                bus.READ = 1'b0;
            end else begin
                n++;
                @(negedge clk);
            end
        end
        compared++;
        if (rd != 3) begin mismatched++; $display("FAIL midreset_wait got=%0d want=3", rd); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared += 4;
        if (bus.mem_read !== 1'b0)    begin mismatched++; $display("FAIL midreset_mem_read got=%b want=0", bus.mem_read); end
        if (bus.HIT_COUNT !== 16'd0)  begin mismatched++; $display("FAIL midreset_hit got=%0d want=0", bus.HIT_COUNT); end
        if (bus.MISS_COUNT !== 16'd0) begin mismatched++; $display("FAIL midreset_miss got=%0d want=0", bus.MISS_COUNT); end
        if (bus.BUSYWAIT !== 1'b0)    begin mismatched++; $display("FAIL midreset_busywait got=%b want=0", bus.BUSYWAIT); end
        $display("reset mid-refill mem_read=%b busywait=%b", bus.mem_read, bus.BUSYWAIT);
        model_clear();
        mh = 0;
        mm = 0;
        void'(model_access(32'h100));
        fetch(32'h100, stall, instr, maddr);
        compared += 2;
        if (stall !== lat + 3)           begin mismatched++; $display("FAIL midreset_refetch got=%0d want=%0d", stall, lat + 3); end
        if (instr !== exp_word(32'h100)) begin mismatched++; $display("FAIL midreset_instr got=%08h want=%08h", instr, exp_word(32'h100)); end
    endtask

    task automatic test_random();
        int stall, maddr, addr, r;
        logic [31:0] instr;
        bit h;
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 99);
            if (r < 8) begin
                @(negedge clk);
                bus.READ  = 1'b0;
                bus.FLUSH = 1'b1;
                model_clear();
                @(negedge clk);
                bus.FLUSH = 1'b0;
                $display("flush");
            end else if (r < 18) begin
                idle($urandom_range(1, 3));
            end else begin
                lat  = $urandom_range(1, 4);
                addr = $urandom_range(0, 511);
                h    = model_access(addr);
                fetch(addr, stall, instr, maddr);
                compared += 2;
                if (stall !== (h ? 0 : lat + 3)) begin mismatched++; $display("FAIL rand_stall addr=%03h got=%0d want=%0d", addr, stall, h ? 0 : lat + 3); end
                if (instr !== exp_word(addr))    begin mismatched++; $display("FAIL rand_instr addr=%03h got=%08h want=%08h", addr, instr, exp_word(addr)); end
                if (!h) begin
                    compared++;
                    if (maddr !== (addr >> OFF)) begin mismatched++; $display("FAIL rand_mem_addr addr=%03h got=%0d want=%0d", addr, maddr, addr >> OFF); end
                end
            end
        end
        idle(1);
        compared += 2;
        if (int'(bus.HIT_COUNT) !== mh)  begin mismatched++; $display("FAIL rand_hit_count got=%0d want=%0d", bus.HIT_COUNT, mh); end
        if (int'(bus.MISS_COUNT) !== mm) begin mismatched++; $display("FAIL rand_miss_count got=%0d want=%0d", bus.MISS_COUNT, mm); end
    endtask

    task automatic test_saturation();
        int stall, maddr, a;
        logic [31:0] instr;
        // 0x008 -> block 1, line 1; memory always ready so a miss stalls 4 cycles
        fetch2(32'h008, stall, instr, maddr);
        compared += 3;
        if (stall !== 4)              begin mismatched++; $display("FAIL sat_miss_stall got=%0d want=4", stall); end
        if (maddr !== 1)              begin mismatched++; $display("FAIL sat_mem_addr got=%0d want=1", maddr); end
        if (instr !== mem_word(1, 0)) begin mismatched++; $display("FAIL sat_instr got=%08h want=%08h", instr, mem_word(1, 0)); end
        for (int i = 0; i < 5; i++) begin
            a = (i % 2 == 0) ? 32'h00C : 32'h008;
            fetch2(a, stall, instr, maddr);
            compared += 2;
            if (stall !== 0)                             begin mismatched++; $display("FAIL sat_hit_stall got=%0d want=0", stall); end
            if (instr !== mem_word(1, (a >> 2) % 2))     begin mismatched++; $display("FAIL sat_hit_instr got=%08h want=%08h", instr, mem_word(1, (a >> 2) % 2)); end
        end
        idle(1);
        compared += 2;
        if (bus2.HIT_COUNT !== 2'd3)  begin mismatched++; $display("FAIL sat_hit_count got=%0d want=3", bus2.HIT_COUNT); end
        if (bus2.MISS_COUNT !== 2'd1) begin mismatched++; $display("FAIL sat_miss_count got=%0d want=1", bus2.MISS_COUNT); end
        // line 0 fill must leave line 1 untouched
        fetch2(32'h000, stall, instr, maddr);
        compared += 2;
        if (stall !== 4) begin mismatched++; $display("FAIL sat_line0_stall got=%0d want=4", stall); end
        if (maddr !== 0) begin mismatched++; $display("FAIL sat_line0_addr got=%0d want=0", maddr); end
        fetch2(32'h00C, stall, instr, maddr);
        compared++;
        if (stall !== 0) begin mismatched++; $display("FAIL sat_line1_kept got=%0d want=0", stall); end
        idle(1);
        compared += 2;
        if (bus2.HIT_COUNT !== 2'd3)  begin mismatched++; $display("FAIL sat_hit_hold got=%0d want=3", bus2.HIT_COUNT); end
        if (bus2.MISS_COUNT !== 2'd2) begin mismatched++; $display("FAIL sat_miss_count2 got=%0d want=2", bus2.MISS_COUNT); end
    endtask

    initial begin
        bus.READ     = 1'b0;
        bus.ADDRESS  = '0;
        bus.FLUSH    = 1'b0;
        bus2.READ    = 1'b0;
        bus2.ADDRESS = '0;
        bus2.FLUSH   = 1'b0;
        test_reset();
        test_cold_miss();
        test_spatial_hits();
        test_conflict();
        test_flush();
        test_flush_refill();
        test_reset_mid_refill();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
